// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command stream to APB requester with wait-state timeout
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  state_t state;
  logic [CW-1:0] cnt;
  logic expired;
  logic done;
  assign cmd_ready = state == IDLE;
  // the cycle that would bring the wait count to TIMEOUT_CYCLES aborts; pready in that cycle still wins
  assign expired = TIMEOUT_CYCLES != 0 && cnt >= LIMIT;
  assign done = pready || expired;
  // transfer sequencer with registered APB and response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          pwrite <= cmd_write;
          paddr  <= cmd_addr;
          pwdata <= cmd_write ? cmd_wdata : '0;
          psel   <= 1'b1;
          state  <= SETUP;
        end
        SETUP: begin
          penable <= 1'b1;
          cnt     <= '0;
          state   <= ACCESS;
        end
        ACCESS: if (done) begin
          rsp_rdata <= pready && !pwrite ? prdata : '0;
          rsp_error <= pready ? pslverr : 1'b1;
          rsp_valid <= 1'b1;
          psel      <= 1'b0;
          penable   <= 1'b0;
          state     <= RESP;
        end else begin
          cnt <= &cnt ? cnt : cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
